stc0_readback: RTL and testbench



---
 rtl/stc0_readback_pkg.sv | 34 +++
 rtl/stc0_sync_fifo.sv | 67 ++++++
 rtl/stc0_readback.sv | 171 +++++++++++++++++
 tb/tb_stc0_readback.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stc0_readback_pkg.sv
// Shared definitions for stc0_readback: RM_RDBK region decode, register offsets, CTRL bit positions.
// No logic of its own; the region sits in WriteAddr/ReadAddr[23:16], the register offset in [15:2].
// Backpressure: not applicable.
package stc0_readback_pkg;

    localparam int RMH = 23;
    localparam int RML = 16;
    localparam int RAW = RML - 2;

    localparam logic [RMH-RML:0] RM_RDBK = 8'hA5;

    typedef enum logic [RAW-1:0] {
        RA_RDBK_CTRL   = 14'h0000,
        RA_RDBK_CAPLEN = 14'h0001,
        RA_RDBK_STATUS = 14'h0002,
        RA_RDBK_COUNT  = 14'h0003,
        RA_RDBK_APOP   = 14'h0004,
        RA_RDBK_BPOP   = 14'h0005,
        RA_RDBK_APEEK  = 14'h0006,
        RA_RDBK_BPEEK  = 14'h0007
    } rdbk_reg_e;

    localparam int RB_RDBKCTRL_CAPEN = 0;
    localparam int RB_RDBKCTRL_FLUSH = 1;

    function automatic logic in_rdbk_region(input logic [23:2] addr);
        return addr[RMH:RML] == RM_RDBK;
    endfunction

    function automatic logic [RAW-1:0] reg_offset(input logic [23:2] addr);
        return addr[RML-1:2];
    endfunction

endpackage

// File: rtl/stc0_sync_fifo.sv
// Single-clock FIFO with push/pop/flush; head is the current read word (first-word fall-through).
// Latency: a pushed word is visible at head the cycle after the push when the FIFO was empty.
// Backpressure: none; push while full (without pop) is dropped, the caller flags overflow.
module stc0_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  do_push, do_pop;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // A pop frees a slot for a same-cycle push; on an empty FIFO both pointers advance so the level stays 0.
    always_comb begin
        do_push  = push && !flush && (!full || pop);
        do_pop   = pop && !flush && (!empty || push);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/stc0_readback.sv
// Captures FFT port A/B samples into two FIFOs and returns them as a bus read responder in RM_RDBK.
// Latency: ReadReq in cycle N answers with ReadDataValid/ReadData in N+1; optional STC0_RDBK_PEEK_EN adds APEEK/BPEEK.
// Backpressure: none on ingress; pushes into a full FIFO are dropped and set a sticky overflow bit.
module stc0_readback
    import stc0_readback_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH_LOG2 = 5
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [DATA_WIDTH*2-1:0] AIngress,
    input  logic                    AIngressValid,
    input  logic [DATA_WIDTH*2-1:0] BIngress,
    input  logic                    BIngressValid,
    input  logic [23:2]             WriteAddr,
    input  logic [31:0]             WriteData,
    input  logic                    WriteDataValid,
    input  logic [23:2]             ReadAddr,
    input  logic                    ReadReq,
    output logic [31:0]             ReadData,
    output logic                    ReadDataValid,
    output logic                    CaptureDone
);
    localparam int SW = DATA_WIDTH * 2;
    localparam int LW = FIFO_DEPTH_LOG2 + 1;

    logic [SW-1:0]  a_head, b_head;
    logic [LW-1:0]  a_level, b_level;
    logic           a_full, a_empty, b_full, b_empty;

    logic           wr_hit, rd_hit;
    logic [RAW-1:0] wr_reg, rd_reg;
    logic           a_pop, b_pop, flush, cap_active;
    logic           a_push, b_push, a_acc, a_ovf_evt, b_ovf_evt;

    logic           capen_q, capen_d;
    logic           done_q, done_d;
    logic           a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
    logic [31:0]    caplen_q, caplen_d;
    logic [31:0]    count_q, count_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           rvld_q, rvld_d;

    always_comb begin
        wr_hit     = WriteDataValid && in_rdbk_region(WriteAddr);
        rd_hit     = ReadReq && in_rdbk_region(ReadAddr);
        wr_reg     = reg_offset(WriteAddr);
        rd_reg     = reg_offset(ReadAddr);
        a_pop      = rd_hit && (rd_reg == RA_RDBK_APOP);
        b_pop      = rd_hit && (rd_reg == RA_RDBK_BPOP);
        flush      = wr_hit && (wr_reg == RA_RDBK_CTRL) && WriteData[RB_RDBKCTRL_FLUSH];
        cap_active = capen_q && !done_q;
        a_push     = cap_active && AIngressValid;
        b_push     = cap_active && BIngressValid;
        a_acc      = a_push && !flush && (!a_full || a_pop);
        a_ovf_evt  = a_push && !flush && a_full && !a_pop;
        b_ovf_evt  = b_push && !flush && b_full && !b_pop;
    end

    stc0_sync_fifo #(.WIDTH(SW), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo_a (
        .clk      (Clk),
        .rst      (Rst),
        .push     (a_push),
        .push_dat (AIngress),
        .pop      (a_pop),
        .flush    (flush),
        .head     (a_head),
        .level    (a_level),
        .full     (a_full),
        .empty    (a_empty)
    );

    stc0_sync_fifo #(.WIDTH(SW), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo_b (
        .clk      (Clk),
        .rst      (Rst),
        .push     (b_push),
        .push_dat (BIngress),
        .pop      (b_pop),
        .flush    (flush),
        .head     (b_head),
        .level    (b_level),
        .full     (b_full),
        .empty    (b_empty)
    );

    // Control and capture state; a CAPTURE_EN 0->1 write restarts counting and overrides the done-clear.
    always_comb begin
        capen_d  = done_q ? 1'b0 : capen_q;
        caplen_d = caplen_q;
        count_d  = count_q;
        done_d   = done_q;
        a_ovf_d  = a_ovf_q;
        b_ovf_d  = b_ovf_q;

        if (a_acc) begin
            count_d = count_q + 32'd1;
            if ((caplen_q != 32'd0) && (count_q + 32'd1 == caplen_q)) done_d = 1'b1;
        end

        if (wr_hit && (wr_reg == RA_RDBK_CTRL)) begin
            capen_d = WriteData[RB_RDBKCTRL_CAPEN];
            if (WriteData[RB_RDBKCTRL_CAPEN] && !capen_q) begin
                count_d = 32'd0;
                done_d  = 1'b0;
            end
        end
        if (wr_hit && (wr_reg == RA_RDBK_CAPLEN)) caplen_d = WriteData;

        if (rd_hit && (rd_reg == RA_RDBK_STATUS)) begin
            a_ovf_d = 1'b0;
            b_ovf_d = 1'b0;
        end
        if (a_ovf_evt) a_ovf_d = 1'b1;
        if (b_ovf_evt) b_ovf_d = 1'b1;
    end

    always_comb begin
        rvld_d  = rd_hit;
        rdata_d = '0;
        if (rd_hit) begin
            case (rd_reg)
                RA_RDBK_CTRL:   rdata_d[RB_RDBKCTRL_CAPEN] = capen_q;
                RA_RDBK_CAPLEN: rdata_d = caplen_q;
                RA_RDBK_STATUS: begin
                    rdata_d[16 +: LW] = b_level;
                    rdata_d[8 +: LW]  = a_level;
                    rdata_d[3]        = b_empty;
                    rdata_d[2]        = a_empty;
                    rdata_d[1]        = b_ovf_q;
                    rdata_d[0]        = a_ovf_q;
                end
                RA_RDBK_COUNT:  rdata_d = count_q;
                RA_RDBK_APOP:   if (!a_empty) rdata_d[SW-1:0] = a_head;
                RA_RDBK_BPOP:   if (!b_empty) rdata_d[SW-1:0] = b_head;
`ifdef STC0_RDBK_PEEK_EN
                RA_RDBK_APEEK:  if (!a_empty) rdata_d[SW-1:0] = a_head;
                RA_RDBK_BPEEK:  if (!b_empty) rdata_d[SW-1:0] = b_head;
`endif
                default:        rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            capen_q  <= 1'b0;
            done_q   <= 1'b0;
            a_ovf_q  <= 1'b0;
            b_ovf_q  <= 1'b0;
            caplen_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvld_q   <= 1'b0;
        end else begin
            capen_q  <= capen_d;
            done_q   <= done_d;
            a_ovf_q  <= a_ovf_d;
            b_ovf_q  <= b_ovf_d;
            caplen_q <= caplen_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvld_q   <= rvld_d;
        end
    end

    assign ReadData      = rdata_q;
    assign ReadDataValid = rvld_q;
    assign CaptureDone   = done_q;

endmodule

// File: tb/tb_stc0_readback.sv
// Randomized and directed bench for stc0_readback with a queue-based reference model and a response scoreboard.
module tb_stc0_readback;
    import stc0_readback_pkg::*;

    localparam int DEPTH = 32;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] AIngress = '0, BIngress = '0, WriteData = '0;
    logic        AIngressValid = 1'b0, BIngressValid = 1'b0, WriteDataValid = 1'b0, ReadReq = 1'b0;
    logic [23:2] WriteAddr = '0, ReadAddr = '0;
    logic [31:0] ReadData;
    logic        ReadDataValid, CaptureDone;

    stc0_readback #(.DATA_WIDTH(16), .FIFO_DEPTH_LOG2(5)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .AIngress       (AIngress),
        .AIngressValid  (AIngressValid),
        .BIngress       (BIngress),
        .BIngressValid  (BIngressValid),
        .WriteAddr      (WriteAddr),
        .WriteData      (WriteData),
        .WriteDataValid (WriteDataValid),
        .ReadAddr       (ReadAddr),
        .ReadReq        (ReadReq),
        .ReadData       (ReadData),
        .ReadDataValid  (ReadDataValid),
        .CaptureDone    (CaptureDone)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        int          cyc;
        string       nm;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: FIFOs as plain queues, registers as variables.
    logic [31:0] mq[2][$];
    bit          m_capen, m_done, m_ovf[2];
    logic [31:0] m_caplen, m_count;

    // Staged inputs for the next cycle; tick() applies them and then clears them.
    logic        s_av, s_bv, s_we, s_re, s_rs;
    logic [31:0] s_ad, s_bd, s_wd;
    logic [21:0] s_wa, s_ra;

    task automatic clear_stage();
        s_av = 0; s_bv = 0; s_we = 0; s_re = 0; s_rs = 0;
        s_ad = '0; s_bd = '0; s_wd = '0; s_wa = '0; s_ra = '0;
    endtask

    task automatic model_reset();
        mq[0].delete(); mq[1].delete();
        m_capen = 0; m_done = 0; m_ovf[0] = 0; m_ovf[1] = 0;
        m_caplen = '0; m_count = '0;
    endtask

    task automatic tick();
        bit          rhit, whit, fl, act, nd, capen_new, acc;
        bit          push[2], pop[2];
        logic [31:0] din[2];
        logic [13:0] rr, wo;
        logic [31:0] ex;
        @(negedge Clk);
        Rst = s_rs;
        AIngressValid = s_av; AIngress = s_ad;
        BIngressValid = s_bv; BIngress = s_bd;
        WriteDataValid = s_we; WriteAddr = s_wa; WriteData = s_wd;
        ReadReq = s_re; ReadAddr = s_ra;

        rhit = s_re && (s_ra[21:14] == RM_RDBK);
        whit = s_we && (s_wa[21:14] == RM_RDBK);
        rr   = s_ra[13:0];
        wo   = s_wa[13:0];
        if (s_rs) begin
            model_reset();
        end else begin
            if (rhit) begin
                ex = '0;
                case (rr)
                    RA_RDBK_CTRL:   ex = {31'd0, m_capen};
                    RA_RDBK_CAPLEN: ex = m_caplen;
                    RA_RDBK_STATUS: ex = (32'(mq[1].size()) << 16) | (32'(mq[0].size()) << 8)
                                         | (32'(mq[1].size() == 0) << 3) | (32'(mq[0].size() == 0) << 2)
                                         | (32'(m_ovf[1]) << 1) | 32'(m_ovf[0]);
                    RA_RDBK_COUNT:  ex = m_count;
                    RA_RDBK_APOP:   ex = (mq[0].size() > 0) ? mq[0][0] : 32'd0;
                    RA_RDBK_BPOP:   ex = (mq[1].size() > 0) ? mq[1][0] : 32'd0;
`ifdef STC0_RDBK_PEEK_EN
                    RA_RDBK_APEEK:  ex = (mq[0].size() > 0) ? mq[0][0] : 32'd0;
                    RA_RDBK_BPEEK:  ex = (mq[1].size() > 0) ? mq[1][0] : 32'd0;
`endif
                    default:        ex = '0;
                endcase
                exp_q.push_back('{ex, cyc + 1, $sformatf("rd_%0h", rr)});
            end

            fl  = whit && (wo == RA_RDBK_CTRL) && s_wd[1];
            act = m_capen && !m_done;
            push[0] = act && s_av; push[1] = act && s_bv;
            pop[0]  = rhit && (rr == RA_RDBK_APOP);
            pop[1]  = rhit && (rr == RA_RDBK_BPOP);
            din[0]  = s_ad; din[1] = s_bd;
            nd = m_done;
            if (rhit && rr == RA_RDBK_STATUS) begin
                m_ovf[0] = 0; m_ovf[1] = 0;
            end
            for (int f = 0; f < 2; f++) begin
                acc = 0;
                if (fl) begin
                    mq[f].delete();
                end else if (push[f]) begin
                    // Push and pop on an empty FIFO: pop yields 0 and the level stays 0.
                    if (mq[f].size() == 0 && pop[f]) begin
                        acc = 1;
                    end else if (mq[f].size() < DEPTH || pop[f]) begin
                        if (pop[f]) void'(mq[f].pop_front());
                        mq[f].push_back(din[f]);
                        acc = 1;
                    end else begin
                        m_ovf[f] = 1;
                    end
                end else if (pop[f] && mq[f].size() > 0) begin
                    void'(mq[f].pop_front());
                end
                if (f == 0 && acc) begin
                    m_count = m_count + 1;
                    if (m_caplen != 0 && m_count == m_caplen) nd = 1;
                end
            end
            capen_new = m_done ? 1'b0 : m_capen;
            if (whit && wo == RA_RDBK_CTRL) begin
                capen_new = s_wd[0];
                if (s_wd[0] && !m_capen) begin
                    m_count = 0;
                    nd = 0;
                end
            end
            if (whit && wo == RA_RDBK_CAPLEN) m_caplen = s_wd;
            m_capen = capen_new;
            m_done  = nd;
        end
        clear_stage();
    endtask

    function automatic logic [21:0] addr_of(input logic [13:0] r);
        return {RM_RDBK, r};
    endfunction

    task automatic rd(input logic [13:0] r);
        s_re = 1; s_ra = addr_of(r); tick();
    endtask

    task automatic wr(input logic [13:0] r, input logic [31:0] d);
        s_we = 1; s_wa = addr_of(r); s_wd = d; tick();
    endtask

    task automatic ing(input bit av, input logic [31:0] ad, input bit bv, input logic [31:0] bd);
        s_av = av; s_ad = ad; s_bv = bv; s_bd = bd; tick();
    endtask

    // Scoreboard monitor: compares every response and the CaptureDone level one step after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (mon_en) begin
                checks++;
                if (CaptureDone !== m_done) begin
                    errors++;
                    $display("FAIL capture_done cyc=%0d got=%b exp=%b", cyc, CaptureDone, m_done);
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++; errors++;
                    $display("FAIL %s missing response cyc=%0d exp=%h", e.nm, e.cyc, e.d);
                end
                if (ReadDataValid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        errors++;
                        $display("FAIL unexpected_rsp cyc=%0d got=%h exp=none", cyc, ReadData);
                    end else begin
                        e = exp_q.pop_front();
                        if (ReadData !== e.d) begin
                            errors++;
                            $display("FAIL %s cyc=%0d got=%h exp=%h", e.nm, cyc, ReadData, e.d);
                        end
                    end
                end else if (ReadDataValid !== 1'b0) begin
                    checks++; errors++;
                    $display("FAIL rdvalid_x cyc=%0d got=%b exp=0/1", cyc, ReadDataValid);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        int r;
        clear_stage();
        model_reset();
        s_rs = 1; tick();
        s_rs = 1; tick();
        mon_en = 1;

        rd(RA_RDBK_STATUS);
        rd(RA_RDBK_CTRL);
        rd(RA_RDBK_COUNT);

        wr(RA_RDBK_CAPLEN, 32'd0);
        wr(RA_RDBK_CTRL, 32'd1);
        ing(1, 32'h0001_0002, 0, '0);
        ing(1, 32'h0003_0004, 0, '0);
        rd(RA_RDBK_APOP); rd(RA_RDBK_APOP); rd(RA_RDBK_APOP);
        rd(RA_RDBK_COUNT);

        for (int i = 1; i <= 33; i++) ing(1, i, 0, '0);
        rd(RA_RDBK_STATUS);
        rd(RA_RDBK_STATUS);
        for (int i = 0; i < 32; i++) rd(RA_RDBK_APOP);
        rd(RA_RDBK_STATUS);

        wr(RA_RDBK_CTRL, 32'd3);
        wr(RA_RDBK_CAPLEN, 32'd4);
        wr(RA_RDBK_CTRL, 32'd0);
        wr(RA_RDBK_CTRL, 32'd1);
        for (int i = 1; i <= 6; i++) ing(1, 32'h100 + i, 1, 32'h200 + i);
        tick();
        rd(RA_RDBK_COUNT); rd(RA_RDBK_CTRL); rd(RA_RDBK_STATUS);

        wr(RA_RDBK_CAPLEN, 32'd0);
        wr(RA_RDBK_CTRL, 32'd2);
        wr(RA_RDBK_CTRL, 32'd1);
        for (int i = 0; i < 32; i++) ing(1, 32'hA000 + i, 0, '0);
        s_av = 1; s_ad = 32'hBEEF; s_re = 1; s_ra = addr_of(RA_RDBK_APOP); tick();
        rd(RA_RDBK_STATUS);

        wr(RA_RDBK_CTRL, 32'd3);
        for (int i = 0; i < 10; i++) ing(1, 32'hC000 + i, 1, 32'hD000 + i);
        s_rs = 1; tick();
        rd(RA_RDBK_STATUS); rd(RA_RDBK_COUNT); rd(RA_RDBK_CTRL);
        wr(RA_RDBK_CTRL, 32'd1);
        for (int i = 0; i < 3; i++) ing(1, 32'hE000 + i, 1, 32'hF000 + i);
        rd(RA_RDBK_APEEK); rd(RA_RDBK_STATUS); rd(RA_RDBK_BPEEK);
        s_re = 1; s_ra = addr_of(14'h0020); tick();
        s_re = 1; s_ra = {8'h00, 14'h0002}; tick();

        for (int i = 0; i < 3000; i++) begin
            s_av = ($urandom_range(0, 2) != 0); s_ad = $urandom;
            s_bv = ($urandom_range(0, 2) != 0); s_bd = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                s_re = 1;
                r = $urandom_range(0, 13);
                if (r <= 7)       s_ra = addr_of(14'(r));
                else if (r <= 10) s_ra = addr_of((r % 2) ? 14'(RA_RDBK_APOP) : 14'(RA_RDBK_BPOP));
                else if (r == 11) s_ra = addr_of(14'h0011);
                else              s_ra = {8'h3C, 14'(r)};
            end
            if ($urandom_range(0, 29) == 0) begin
                s_we = 1;
                r = $urandom_range(0, 5);
                if (r <= 3) begin
                    s_wa = addr_of(RA_RDBK_CTRL);
                    s_wd = {30'd0, ($urandom_range(0, 3) == 0), (r != 0)};
                end else if (r == 4) begin
                    s_wa = addr_of(RA_RDBK_CAPLEN);
                    s_wd = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
                end else begin
                    s_wa = addr_of(RA_RDBK_STATUS);
                    s_wd = $urandom;
                end
            end
            if ($urandom_range(0, 999) == 0) begin
                s_rs = 1; s_re = 0;
            end
            tick();
        end

        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain outstanding=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
